// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers: state encoding and bubble value.
// Each state's encoding doubles as the held-entry count.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_FULL  = ST_FULL,
        S_SKID  = ST_SKID
    } pipe_state_t;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load and load-default controls; load-default wins over load.
// One-cycle update, no handshake of its own: the owning stage decides when it loads.
module pipe_data_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  i_load,
    input  logic                  i_load_default,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [DATA_WIDTH-1:0] i_default,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (i_load_default) begin
            r_data <= i_default;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/pipe_skid_register.sv
// Valid/ready pipeline stage register with an optional skid entry that makes in_ready a flop.
// One cycle enqueue-to-out_valid, one transfer per cycle; empty and flushed slots read default_data.
module pipe_skid_register
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_READY  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] default_data,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [1:0]            count
);

    pipe_state_t           r_state;
    pipe_state_t           w_state_nxt;
    logic                  w_enq;
    logic                  w_deq;
    logic                  w_main_ld;
    logic                  w_main_ld_def;
    logic [DATA_WIDTH-1:0] w_main_d;
    logic                  w_skid_ld;
    logic                  w_skid_ld_def;
    logic [DATA_WIDTH-1:0] w_skid_q;

    assign w_enq     = in_valid && in_ready;
    assign w_deq     = out_valid && out_ready;
    assign out_valid = (r_state != S_EMPTY);
    assign count     = r_state;

    always_ff @(posedge clk) begin
        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_main_ld     = 1'b0;
        w_main_ld_def = 1'b0;
        w_main_d      = in_data;
        w_skid_ld     = 1'b0;
        w_skid_ld_def = 1'b0;
        if (reset || flush) begin
            w_state_nxt   = S_EMPTY;
            w_main_ld_def = 1'b1;
            w_skid_ld_def = 1'b1;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_enq) begin
                        w_main_ld   = 1'b1;
                        w_state_nxt = S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_enq && w_deq) begin
                        w_main_ld = 1'b1;
                    end else if (w_enq && (REG_READY != 0)) begin
                        w_skid_ld   = 1'b1;
                        w_state_nxt = S_SKID;
                    end else if (w_deq) begin
                        w_main_ld_def = 1'b1;
                        w_state_nxt   = S_EMPTY;
                    end
                end
                S_SKID: begin
                    if (w_deq) begin
                        w_main_ld     = 1'b1;
                        w_main_d      = w_skid_q;
                        w_skid_ld_def = 1'b1;
                        w_state_nxt   = S_FULL;
                    end
                end
                default: begin
                    w_state_nxt   = S_EMPTY;
                    w_main_ld_def = 1'b1;
                end
            endcase
        end
    end

    pipe_data_reg #(.DATA_WIDTH(DATA_WIDTH)) u_main (
        .clk           (clk),
        .i_load        (w_main_ld),
        .i_load_default(w_main_ld_def),
        .i_data        (w_main_d),
        .i_default     (default_data),
        .o_data        (out_data)
    );

    generate
        if (REG_READY != 0) begin : g_skid
            logic r_in_ready;

            pipe_data_reg #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
                .clk           (clk),
                .i_load        (w_skid_ld),
                .i_load_default(w_skid_ld_def),
                .i_data        (in_data),
                .i_default     (default_data),
                .o_data        (w_skid_q)
            );

            // Ready is precomputed from next state so upstream never sees a combinational stall path.
            always_ff @(posedge clk) begin
                r_in_ready <= (w_state_nxt != S_SKID);
            end

            assign in_ready = r_in_ready;
        end else begin : g_noskid
            assign w_skid_q = default_data;
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

endmodule
